// File: rtl/hc_85.sv
// hc_85: registered 4-bit magnitude comparator with cascade inputs.
// Several instances chain into wider comparators. The less-significant
// stage feeds I1/I2/I3, and these decide the result only when A equals B.
module hc_85 (
  input  logic clk,
  input  logic rst,
  input  logic A3,
  input  logic A2,
  input  logic A1,
  input  logic A0,
  input  logic B3,
  input  logic B2,
  input  logic B1,
  input  logic B0,
  input  logic I1,
  input  logic I2,
  input  logic I3,
  output logic Q1,
  output logic Q2,
  output logic Q3
);

  logic [3:0] w_a;
  logic [3:0] w_b;
  logic       w_gt;
  logic       w_lt;
  logic       w_eq;
  logic       w_q1;
  logic       w_q2;
  logic       w_q3;
  logic       r_q1;
  logic       r_q2;
  logic       r_q3;

  assign w_a = {A3, A2, A1, A0};
  assign w_b = {B3, B2, B1, B0};

  // Unsigned magnitude compare: the most significant differing bit decides.
  always_comb begin
    w_gt = (w_a > w_b);
    w_lt = (w_a < w_b);
    w_eq = (w_a == w_b);
  end

  // Cascade resolution when the operands are equal.
  // The cascade truth table is written as AND/OR terms rather than an
  // if/else chain. An if/else chain would send an unknown cascade input
  // down the else branch. These terms let an X on I1..I3 reach the
  // outputs when w_eq is set. When w_eq is clear, the AND with w_eq
  // forces the cascade terms to 0, so X on I1..I3 has no effect.
  //   I2=1            -> 0/1/0
  //   I2=0 I1=1 I3=0  -> 1/0/0
  //   I2=0 I1=0 I3=1  -> 0/0/1
  //   I2=0 I1=1 I3=1  -> 0/0/0
  //   I2=0 I1=0 I3=0  -> 1/0/1
  always_comb begin
    w_q1 = w_gt | (w_eq & ~I2 & ~I3);
    w_q2 = w_eq & I2;
    w_q3 = w_lt | (w_eq & ~I2 & ~I1);
  end

  // Output register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q1 <= 1'b0;
      r_q2 <= 1'b0;
      r_q3 <= 1'b0;
    end else begin
      r_q1 <= w_q1;
      r_q2 <= w_q2;
      r_q3 <= w_q3;
    end
  end

  assign Q1 = r_q1;
  assign Q2 = r_q2;
  assign Q3 = r_q3;

endmodule

// File: tb/tb_hc_85.sv
// tb_hc_85: directed and exhaustive checks of the hc_85 registered comparator.
module tb_hc_85;

  logic clk;
  logic rst;
  logic A3, A2, A1, A0;
  logic B3, B2, B1, B0;
  logic I1, I2, I3;
  logic Q1, Q2, Q3;

  int n_tests;
  int n_fail;

  hc_85 dut (
    .clk(clk), .rst(rst),
    .A3(A3), .A2(A2), .A1(A1), .A0(A0),
    .B3(B3), .B2(B2), .B1(B1), .B0(B0),
    .I1(I1), .I2(I2), .I3(I3),
    .Q1(Q1), .Q2(Q2), .Q3(Q3)
  );

  // 10 ns clock period; rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result {Q1,Q2,Q3}, written from the behavioural table.
  function automatic logic [2:0] ref_q(input logic [3:0] a, input logic [3:0] b,
                                       input logic c1, input logic c2, input logic c3);
    if (a > b) return 3'b100;
    if (a < b) return 3'b001;
    if (c2)    return 3'b010;
    case ({c1, c3})
      2'b10:   return 3'b100;
      2'b01:   return 3'b001;
      2'b11:   return 3'b000;
      default: return 3'b101;
    endcase
  endfunction

  task automatic check(input string tag, input logic [2:0] exp);
    logic [2:0] obs;
    obs = {Q1, Q2, Q3};
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: Q1Q2Q3 observed %b expected %b at %0t", tag, obs, exp, $time);
      $error("check %s did not match", tag);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b,
                       input logic c1, input logic c2, input logic c3);
    {A3, A2, A1, A0} = a;
    {B3, B2, B1, B0} = b;
    I1 = c1; I2 = c2; I3 = c3;
  endtask

  // Drive the inputs, let one rising edge register them, then sample 1 ns later.
  task automatic step(input string tag, input logic [3:0] a, input logic [3:0] b,
                      input logic c1, input logic c2, input logic c3,
                      input logic [2:0] exp);
    drive(a, b, c1, c2, c3);
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // Reset is held with inputs that give A>B. No clock edge has occurred yet.
    rst = 1'b1;
    drive(4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0);
    #3;
    check("reset_async_no_edge", 3'b000);
    @(posedge clk); #1;
    check("reset_held_over_edge", 3'b000);

    // Release reset between edges. The next edge loads the current result.
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("reset_release_load", 3'b100);

    // Inequality
    step("lt_0010_0101", 4'b0010, 4'b0101, 1'b0, 1'b1, 1'b0, 3'b001);
    step("gt_0110_0101", 4'b0110, 4'b0101, 1'b1, 1'b0, 1'b1, 3'b100);

    // Equal operands: sweep the cascade inputs
    step("eq_c000", 4'b0101, 4'b0101, 1'b0, 1'b0, 1'b0, 3'b101);
    step("eq_c001", 4'b0101, 4'b0101, 1'b0, 1'b0, 1'b1, 3'b001);
    step("eq_c100", 4'b0101, 4'b0101, 1'b1, 1'b0, 1'b0, 3'b100);
    step("eq_c101", 4'b0101, 4'b0101, 1'b1, 1'b0, 1'b1, 3'b000);
    step("eq_c111", 4'b0101, 4'b0101, 1'b1, 1'b1, 1'b1, 3'b010);
    step("eq_standalone", 4'b1010, 4'b1010, 1'b0, 1'b1, 1'b0, 3'b010);

    // The MSB decides, and the cascade (I2=1) is ignored
    step("msb_gt_1000_0111", 4'b1000, 4'b0111, 1'b0, 1'b1, 1'b0, 3'b100);
    step("msb_lt_0111_1000", 4'b0111, 4'b1000, 1'b0, 1'b1, 1'b0, 3'b001);
    step("lsb_gt_0001_0000", 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 3'b100);
    step("max_lt_1110_1111", 4'b1110, 4'b1111, 1'b1, 1'b0, 1'b0, 3'b001);

    // Assert reset mid-operation: the outputs clear without waiting for an edge
    #2 rst = 1'b1;
    #1;
    check("reset_mid_async", 3'b000);
    #3 rst = 1'b0;
    step("after_mid_reset", 4'b0011, 4'b0011, 1'b0, 1'b0, 1'b0, 3'b101);

    // Exhaustive sweep against the reference function, with one reset pulse
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 8; c++) begin
          logic [2:0] cv;
          cv = c[2:0];
          step("sweep", a[3:0], b[3:0], cv[2], cv[1], cv[0],
               ref_q(a[3:0], b[3:0], cv[2], cv[1], cv[0]));
          if (a == 9 && b == 4 && c == 3) begin
            #2 rst = 1'b1;
            #1;
            check("sweep_reset", 3'b000);
            #2 rst = 1'b0;
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety bound so the run always ends
  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
